// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: sequencer for the HI/LO register pair.
// Handles MULT/MULTU (one latched cycle), DIV/DIVU (WIDTH-step restoring
// divide), and MTHI/MTLO (same-cycle write). Stalls the pipeline while busy.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, op, a, b   EX-stage request: opcode and rs/rt operands
//   flush             abort any operation, no write
//   stall             hold IF..EX this cycle
//   hi_wdata/lo_wdata HI/LO write data (0 when no strobe)
//   hilo_we/hi_we/lo_we  mutually exclusive write strobes
//   busy              sequencer not in IDLE
module hilo_muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata,
    output logic             hilo_we,
    output logic             hi_we,
    output logic             lo_we,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_NONE0 = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_NONE7 = 3'd7;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    // opa: multiplicand, or dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] rem;
    logic             mul_signed;
    logic             sign_q;
    logic             sign_r;

    logic             accept;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   trial;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;

    assign accept = (state == IDLE) && start && !flush &&
                    (op != OP_NONE0) && (op != OP_NONE7);

    // Magnitudes only for signed DIV; DIVU passes operands through
    assign abs_a = (op == OP_DIV && a[WIDTH-1]) ? -a : a;
    assign abs_b = (op == OP_DIV && b[WIDTH-1]) ? -b : b;

    // One restoring step: shift next dividend bit into the partial remainder
    assign trial    = {rem, opa[WIDTH-1]};
    assign ge       = trial >= {1'b0, opb};
    assign rem_next = ge ? (trial[WIDTH-1:0] - opb) : trial[WIDTH-1:0];

    assign ext_a = mul_signed ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
    assign ext_b = mul_signed ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
    assign prod  = ext_a * ext_b;

    assign busy = (state != IDLE);

    // Sequencer state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            mul_signed <= 1'b0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MULT || op == OP_MULTU) begin
                            opa        <= a;
                            opb        <= b;
                            mul_signed <= (op == OP_MULT);
                            state      <= MUL;
                        end else if (op == OP_DIV || op == OP_DIVU) begin
                            if (b == '0) begin
                                opa    <= '1;
                                rem    <= a;
                                sign_q <= 1'b0;
                                sign_r <= 1'b0;
                                state  <= DONE;
                            end else begin
                                opa    <= abs_a;
                                opb    <= abs_b;
                                rem    <= '0;
                                sign_q <= (op == OP_DIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                                sign_r <= (op == OP_DIV) && a[WIDTH-1];
                                cnt    <= CW'(WIDTH);
                                state  <= DIV;
                            end
                        end
                    end
                end
                MUL: state <= IDLE;
                DIV: begin
                    rem <= rem_next;
                    opa <= {opa[WIDTH-2:0], ge};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes, data and stall; flush and reset silence everything
    always_comb begin
        stall    = 1'b0;
        hilo_we  = 1'b0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        hi_wdata = '0;
        lo_wdata = '0;
        if (!rst && !flush) begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) begin
                            hi_we    = 1'b1;
                            hi_wdata = a;
                        end else if (op == OP_MTLO) begin
                            lo_we    = 1'b1;
                            lo_wdata = a;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                MUL: begin
                    hilo_we  = 1'b1;
                    hi_wdata = prod[2*WIDTH-1:WIDTH];
                    lo_wdata = prod[WIDTH-1:0];
                end
                DIV: stall = 1'b1;
                DONE: begin
                    hilo_we  = 1'b1;
                    lo_wdata = sign_q ? -opa : opa;
                    hi_wdata = sign_r ? -rem : rem;
                end
                default: begin
                    stall = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed testbench for hilo_muldiv_ctrl (WIDTH=32).
module tb_hilo_muldiv_ctrl;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        stall;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
    logic        hilo_we;
    logic        hi_we;
    logic        lo_we;
    logic        busy;

    int n_checks  = 0;
    int n_errors  = 0;
    int hilo_pulses = 0;
    int hi_pulses   = 0;
    int lo_pulses   = 0;
    int excl_viol   = 0;
    int data_viol   = 0;

    hilo_muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .stall    (stall),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .hilo_we  (hilo_we),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Mid-cycle monitor: strobe pulse counts, exclusivity, data-zero rule
    always @(negedge clk) begin
        if (hilo_we === 1'b1) hilo_pulses++;
        if (hi_we === 1'b1) hi_pulses++;
        if (lo_we === 1'b1) lo_pulses++;
        if (int'(hilo_we) + int'(hi_we) + int'(lo_we) > 1) excl_viol++;
        if ((!hilo_we && !hi_we && hi_wdata != 32'd0) ||
            (!hilo_we && !lo_we && lo_wdata != 32'd0)) data_viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 64'({stall, hilo_we, hi_we, lo_we, busy}), 64'd0);
        chk({tag, "_data"}, {hi_wdata, lo_wdata}, 64'd0);
    endtask

    // Present an op, count stall cycles up to the hilo_we write, check results
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic hold, input int exp_stall,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        start = 1'b1;
        op = o;
        a = va;
        b = vb;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (hilo_we === 1'b1) begin
                done = 1'b1;
                break;
            end
            if (stall === 1'b1) n++;
            cyc();
            if (!hold) start = 1'b0;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_stalls"}, 64'(n), 64'(exp_stall));
        chk({tag, "_wr"}, 64'({stall, busy, hi_we, lo_we}), 64'b0100);
        chk({tag, "_hi"}, 64'(hi_wdata), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo_wdata), 64'(exp_lo));
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        start = 1'b0;
        op = 3'd0;
        a = 32'd0;
        b = 32'd0;
        flush = 1'b0;
        cyc();
        cyc();
        chk_idle("in_reset");
        rst = 1'b0;
        cyc();
        chk_idle("after_reset");

        // MTHI / MTLO same-cycle writes
        start = 1'b1; op = OP_MTHI; a = 32'h12345678;
        #1;
        chk("mthi_ctl", 64'({hi_we, stall, hilo_we, lo_we, busy}), 64'b10000);
        chk("mthi_data", 64'(hi_wdata), 64'h12345678);
        cyc();
        start = 1'b0;
        #1;
        chk_idle("mthi_after");

        // Multiply
        cyc();
        run_op("mult", OP_MULT, 32'hFFFFFFFE, 32'h3, 1'b0, 1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        cyc();
        chk_idle("mult_after");
        run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'h3, 1'b0, 1, 32'h2, 32'hFFFFFFFA);
        cyc();

        // Divide
        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        cyc();
        chk_idle("div_after");
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 33, 32'd2, 32'd14);
        cyc();
        run_op("divu_z", OP_DIVU, 32'd5, 32'd0, 1'b0, 1, 32'd5, 32'hFFFFFFFF);
        cyc();
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 33, 32'h0, 32'h80000000);
        cyc();
        run_op("div_mix", OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b0, 33, 32'd1, 32'hFFFFFFFD);
        cyc();

        // Invalid opcodes are not accepted
        start = 1'b1; op = 3'd0;
        #1;
        chk("op0_ctl", 64'({stall, hilo_we, hi_we, lo_we}), 64'd0);
        cyc();
        op = 3'd7;
        #1;
        chk("op7_ctl", 64'({stall, hilo_we, hi_we, lo_we, busy}), 64'd0);
        cyc();
        start = 1'b0;
        #1;
        chk_idle("op_inv_after");

        // flush together with MTHI suppresses the write
        start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF; flush = 1'b1;
        #1;
        chk("flush_mthi", 64'({stall, hilo_we, hi_we, lo_we}), 64'd0);
        cyc();
        start = 1'b0; flush = 1'b0;
        #1;
        chk_idle("flush_mthi_after");

        // flush in the 10th divide iteration
        cyc();
        p0 = hilo_pulses + hi_pulses + lo_pulses;
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        #1;
        chk("fl_acc_stall", 64'(stall), 64'd1);
        cyc();
        start = 1'b0;
        repeat (8) cyc();
        chk("fl_iter", 64'({busy, stall}), 64'b11);
        cyc();
        flush = 1'b1;
        #1;
        chk("fl_cycle", 64'({stall, hilo_we, hi_we, lo_we}), 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk_idle("fl_after");
        chk("fl_no_strobe", 64'(hilo_pulses + hi_pulses + lo_pulses - p0), 64'd0);
        run_op("fl_mult", OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 32'h0, 32'h1);
        cyc();

        // rst in the 10th divide iteration
        p0 = hilo_pulses + hi_pulses + lo_pulses;
        start = 1'b1; op = OP_DIVU; a = 32'd1000; b = 32'd3;
        cyc();
        start = 1'b0;
        repeat (8) cyc();
        chk("rs_iter", 64'({busy, stall}), 64'b11);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk_idle("rs_after");
        chk("rs_no_strobe", 64'(hilo_pulses + hi_pulses + lo_pulses - p0), 64'd0);
        run_op("rs_multu", OP_MULTU, 32'h00010000, 32'h00010000, 1'b0, 1, 32'h1, 32'h0);
        cyc();

        // Back-to-back: DIVU held on start through completion, then MTLO
        p0 = hilo_pulses;
        run_op("b2b", OP_DIVU, 32'd1000, 32'd10, 1'b1, 33, 32'd0, 32'd100);
        cyc();
        op = OP_MTLO; a = 32'hCAFEBABE;
        #1;
        chk("b2b_mtlo_ctl", 64'({lo_we, stall, busy, hilo_we, hi_we}), 64'b10000);
        chk("b2b_mtlo_data", 64'(lo_wdata), 64'hCAFEBABE);
        cyc();
        start = 1'b0;
        #1;
        chk_idle("b2b_after");
        chk("b2b_one_pulse", 64'(hilo_pulses - p0), 64'd1);

        cyc();
        chk("strobe_exclusive", 64'(excl_viol), 64'd0);
        chk("data_zero_rule", 64'(data_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Sequencer for the HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage.
- Runs a single-cycle-latched multiply or a 32-iteration restoring divide, and stalls the pipeline while busy.
- Drives the HI/LO write strobes and data: hi-only, lo-only, or both together.
- Sits between the EX-stage operand muxes and the HI/LO register, and feeds the hazard unit's stall input.

Parameters:
- WIDTH, 32, operand/result width; divide iteration count = WIDTH; counter width = clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a valid HI/LO-class instruction
- op  in  3  0=NONE 1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO 7=NONE
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
- b  in  WIDTH  rt operand (divisor / multiplier)
- flush  in  1  exception/flush from control; aborts any operation
- stall  out  1  hold IF..EX this cycle
- hi_wdata  out  WIDTH  data for HI
- lo_wdata  out  WIDTH  data for LO
- hilo_we  out  1  write both HI and LO this cycle
- hi_we  out  1  write HI only
- lo_we  out  1  write LO only
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock (clk); synchronous active-high reset (rst).
- Reset values: state=IDLE, counter=0, internal regs=0, all outputs 0.
- States: IDLE, MUL, DIV, DONE.
- Acceptance: an op is accepted only in IDLE with start=1, flush=0 and op in 1..6. Call this cycle T.
- MTHI/MTLO, at T, combinationally:
  - MTHI: hi_we=1, hi_wdata=a.
  - MTLO: lo_we=1, lo_wdata=a.
  - stall=0; state stays IDLE.
- MULT/MULTU:
  - At T: stall=1; operands latched; state->MUL.
  - At T+1 in MUL: full 2*WIDTH product is output (MULT signed, MULTU unsigned). hi_wdata=upper half, lo_wdata=lower half, hilo_we=1, stall=0; state->IDLE.
- DIV/DIVU with b!=0:
  - At T: stall=1; operand magnitudes latched (DIV only: absolute value; sign_q=a[msb]^b[msb], sign_r=a[msb]); counter=WIDTH; state->DIV.
  - In DIV: one restoring step per cycle, MSB first. counter decrements each cycle; stall=1.
  - When counter reaches 1 on a step, state->DONE. DIV therefore occupies T+1..T+WIDTH.
  - At T+WIDTH+1 in DONE: lo_wdata=quotient, hi_wdata=remainder (signs applied for DIV). hilo_we=1, stall=0; state->IDLE.
  - Total stall = WIDTH+1 cycles.
- Divide by zero (b==0, DIV or DIVU): no iteration. At T: stall=1, state->DONE with lo=all-ones, hi=a. At T+1: hilo_we=1, stall=0.
- Signed overflow 0x80000000 / -1: quotient 0x80000000, remainder 0. This falls out of the magnitude path; no special case.
- Strobes are mutually exclusive: at most one of hilo_we, hi_we, lo_we is high in any cycle. Data outputs are 0 when no strobe is high.
- Completion cycle: start may still be high (EX has not advanced yet). It is ignored because state!=IDLE. A new op is accepted the following cycle.
- start while busy: ignored.
- flush:
  - In any state, the next state is IDLE with no write. Strobes are forced 0 and stall=0 in the flush cycle.
  - flush and start in the same IDLE cycle: nothing is accepted; MTHI/MTLO strobes are suppressed.
- rst mid-operation: IDLE next cycle, no write, partial results discarded.
- stall is asserted combinationally in the accept cycle and in every cycle where state is MUL (accept only), DIV, or DONE-before-write. It is deasserted exactly in the write cycle.

Test Plan:
- MTHI a=0x12345678 -> same cycle hi_we=1, hi_wdata=0x12345678, stall=0, hilo_we=0, lo_we=0; busy stays 0.
- MULT a=0xFFFFFFFE (-2), b=0x00000003 -> stall 1 cycle. Next cycle hilo_we=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> stall exactly 33 cycles, then hilo_we=1, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIVU a=5, b=0 -> 1 stall cycle, then hilo_we=1, lo=0xFFFFFFFF, hi=5. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV started, flush at cycle 10 of iteration -> next cycle busy=0, stall=0, no strobe ever asserted. A MULT presented the following cycle completes normally. Repeat with rst instead of flush -> same result.
- Back-to-back: DIVU held on start through completion, then MTLO next cycle -> exactly one hilo_we pulse, then lo_we with MTLO data. Verify no double-accept of the DIVU.
